// File: rtl/alu_operand_stage_pkg.sv
// Shared encodings, widths and the buffered-entry record for the ALU operand stage.
package alu_operand_stage_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SLT  = 4'h8;
  localparam logic [3:0] ALU_SLTU = 4'h9;

  localparam logic [1:0] OP1_SEL_RS1  = 2'b00;
  localparam logic [1:0] OP1_SEL_PC   = 2'b01;
  localparam logic [1:0] OP1_SEL_ZERO = 2'b10;

  localparam logic OP2_SEL_RS2 = 1'b0;
  localparam logic OP2_SEL_IMM = 1'b1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [XLEN-1:0]       rs1_val;
    logic [XLEN-1:0]       rs2_val;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       pc;
    logic [1:0]            op1_sel;
    logic                  op2_sel;
    logic [3:0]            opcode;
    logic [REG_ADDR_W-1:0] rd_addr;
  } entry_t;

  // x0 is hardwired, so a writeback aimed at it never replaces a source value.
  function automatic logic [XLEN-1:0] fwd_value(
    input logic                  wb_en,
    input logic [REG_ADDR_W-1:0] wb_addr,
    input logic [XLEN-1:0]       wb_data,
    input logic [REG_ADDR_W-1:0] src_addr,
    input logic [XLEN-1:0]       src_val
  );
    return (wb_en && (wb_addr != '0) && (wb_addr == src_addr)) ? wb_data : src_val;
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode-side, writeback-side and ALU-side signals of the operand stage.
// Handshake: a beat moves on a rising edge where valid && ready; valid must not depend on ready.
interface alu_operand_stage_if;
  import alu_operand_stage_pkg::*;

  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] rs1_addr;
  logic [REG_ADDR_W-1:0] rs2_addr;
  logic [XLEN-1:0]       rs1_data;
  logic [XLEN-1:0]       rs2_data;
  logic [XLEN-1:0]       imm;
  logic [XLEN-1:0]       pc;
  logic [1:0]            op1_sel;
  logic                  op2_sel;
  logic [3:0]            alu_opcode_in;
  logic [REG_ADDR_W-1:0] rd_addr_in;
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [XLEN-1:0]       wb_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       op_1;
  logic [XLEN-1:0]       op_2;
  logic [3:0]            opcode;
  logic [REG_ADDR_W-1:0] rd_addr_out;

  modport master (
    output flush, in_valid, rs1_addr, rs2_addr, rs1_data, rs2_data, imm, pc,
           op1_sel, op2_sel, alu_opcode_in, rd_addr_in, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, op_1, op_2, opcode, rd_addr_out
  );

  modport slave (
    input  flush, in_valid, rs1_addr, rs2_addr, rs1_data, rs2_data, imm, pc,
           op1_sel, op2_sel, alu_opcode_in, rd_addr_in, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, op_1, op_2, opcode, rd_addr_out
  );

endinterface

// File: rtl/alu_operand_stage_operand_entry.sv
// One buffered instruction: valid bit plus stored operands, refreshed by writeback
// both on load and while held.
module operand_entry
  import alu_operand_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  load,
  input  logic                  clear,
  input  entry_t                d,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  valid,
  output entry_t                q
);

  entry_t d_fwd;
  entry_t q_fwd;

  // Loaded data also passes through forwarding, which covers both a fresh capture
  // and an entry moving up from the skid slot in the same cycle as a writeback.
  always_comb begin
    d_fwd         = d;
    d_fwd.rs1_val = fwd_value(wb_en, wb_addr, wb_data, d.rs1_addr, d.rs1_val);
    d_fwd.rs2_val = fwd_value(wb_en, wb_addr, wb_data, d.rs2_addr, d.rs2_val);
    q_fwd         = q;
    q_fwd.rs1_val = fwd_value(wb_en, wb_addr, wb_data, q.rs1_addr, q.rs1_val);
    q_fwd.rs2_val = fwd_value(wb_en, wb_addr, wb_data, q.rs2_addr, q.rs2_val);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d_fwd;
    end else begin
      if (clear) valid <= 1'b0;
      if (valid) q <= q_fwd;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Execute-stage input register: main + skid entry with writeback forwarding,
// registered in_ready, and the OP_1/OP_2 select mux fed only from the main entry.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  alu_operand_stage_if.slave  bus
);

  entry_t in_entry;
  entry_t main_d;
  entry_t main_q;
  entry_t skid_q;
  logic   main_valid;
  logic   skid_valid;
  logic   in_ready_q;
  logic   main_xfer;
  logic   in_acc;
  logic   main_load;
  logic   skid_load;
  logic   skid_clear;
  logic   skid_valid_next;
  logic   unused_main_addrs;

  always_comb begin
    in_entry          = '0;
    in_entry.rs1_addr = bus.rs1_addr;
    in_entry.rs2_addr = bus.rs2_addr;
    in_entry.rs1_val  = bus.rs1_data;
    in_entry.rs2_val  = bus.rs2_data;
    in_entry.imm      = bus.imm;
    in_entry.pc       = bus.pc;
    in_entry.op1_sel  = bus.op1_sel;
    in_entry.op2_sel  = bus.op2_sel;
    in_entry.opcode   = bus.alu_opcode_in;
    in_entry.rd_addr  = bus.rd_addr_in;
  end

  // Skid is only ever occupied while in_ready is low, so an accept never
  // coincides with a skid-to-main move.
  always_comb begin
    main_xfer       = main_valid & bus.out_ready;
    in_acc          = bus.in_valid & in_ready_q;
    main_load       = (skid_valid & main_xfer) | (in_acc & (~main_valid | main_xfer));
    main_d          = skid_valid ? skid_q : in_entry;
    skid_load       = in_acc & main_valid & ~main_xfer;
    skid_clear      = skid_valid & main_xfer;
    skid_valid_next = skid_load | (skid_valid & ~skid_clear);
  end

  operand_entry u_main (
    .clk     (clk),
    .reset   (reset),
    .flush   (bus.flush),
    .load    (main_load),
    .clear   (main_xfer),
    .d       (main_d),
    .wb_en   (bus.wb_en),
    .wb_addr (bus.wb_addr),
    .wb_data (bus.wb_data),
    .valid   (main_valid),
    .q       (main_q)
  );

  operand_entry u_skid (
    .clk     (clk),
    .reset   (reset),
    .flush   (bus.flush),
    .load    (skid_load),
    .clear   (skid_clear),
    .d       (in_entry),
    .wb_en   (bus.wb_en),
    .wb_addr (bus.wb_addr),
    .wb_data (bus.wb_data),
    .valid   (skid_valid),
    .q       (skid_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_q <= 1'b1;
    end else if (bus.flush) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= ~skid_valid_next;
    end
  end

  always_comb begin
    bus.op_1 = '0;
    case (main_q.op1_sel)
      OP1_SEL_RS1: bus.op_1 = main_q.rs1_val;
      OP1_SEL_PC:  bus.op_1 = main_q.pc;
      default:     bus.op_1 = '0;
    endcase
    bus.op_2 = (main_q.op2_sel == OP2_SEL_IMM) ? main_q.imm : main_q.rs2_val;
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = main_valid;
  assign bus.opcode      = main_q.opcode;
  assign bus.rd_addr_out = main_q.rd_addr;

  assign unused_main_addrs = ^{main_q.rs1_addr, main_q.rs2_addr};

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed vectors with literal expectations plus a
// 2-deep in-order queue model compared against the outputs every cycle.
module tb_alu_operand_stage;
  import alu_operand_stage_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  alu_operand_stage_if bus();

  alu_operand_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [31:0] rs1v;
    logic [31:0] rs2v;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [1:0]  s1;
    logic        s2;
    logic [3:0]  opc;
    logic [4:0]  rd;
  } instr_t;

  instr_t model_q[$];
  instr_t new_i;
  int     checks = 0;
  int     errors = 0;
  bit     model_live = 0;
  bit     zero_out = 0;
  bit     m_xfer;
  bit     m_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wb_pick(input logic [4:0] a, input logic [31:0] v,
                                          input logic en, input logic [4:0] wa,
                                          input logic [31:0] wd);
    return (en && wa != 5'd0 && wa == a) ? wd : v;
  endfunction

  function automatic logic [31:0] exp_op1(input instr_t e);
    if (e.s1 == 2'b00) return e.rs1v;
    if (e.s1 == 2'b01) return e.pc;
    return 32'h0;
  endfunction

  function automatic logic [31:0] exp_op2(input instr_t e);
    return e.s2 ? e.imm : e.rs2v;
  endfunction

  // Model: in-order queue of at most two instructions; accept iff fewer than two held.
  always @(posedge clk) begin
    if (reset) begin
      model_q.delete();
      model_live = 1;
      zero_out = 1;
    end else if (model_live) begin
      if (bus.flush) begin
        model_q.delete();
      end else begin
        m_xfer = (model_q.size() > 0) && bus.out_ready;
        m_acc  = bus.in_valid && (model_q.size() < 2);
        foreach (model_q[i]) begin
          model_q[i].rs1v = wb_pick(model_q[i].rs1a, model_q[i].rs1v, bus.wb_en, bus.wb_addr, bus.wb_data);
          model_q[i].rs2v = wb_pick(model_q[i].rs2a, model_q[i].rs2v, bus.wb_en, bus.wb_addr, bus.wb_data);
        end
        if (m_xfer) void'(model_q.pop_front());
        if (m_acc) begin
          new_i.rs1a = bus.rs1_addr;
          new_i.rs2a = bus.rs2_addr;
          new_i.rs1v = wb_pick(bus.rs1_addr, bus.rs1_data, bus.wb_en, bus.wb_addr, bus.wb_data);
          new_i.rs2v = wb_pick(bus.rs2_addr, bus.rs2_data, bus.wb_en, bus.wb_addr, bus.wb_data);
          new_i.imm  = bus.imm;
          new_i.pc   = bus.pc;
          new_i.s1   = bus.op1_sel;
          new_i.s2   = bus.op2_sel;
          new_i.opc  = bus.alu_opcode_in;
          new_i.rd   = bus.rd_addr_in;
          model_q.push_back(new_i);
          zero_out = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_live && !reset) begin
      check("m_in_ready", {31'b0, bus.in_ready}, {31'b0, model_q.size() < 2});
      check("m_out_valid", {31'b0, bus.out_valid}, {31'b0, model_q.size() > 0});
      if (model_q.size() > 0) begin
        check("m_op_1", bus.op_1, exp_op1(model_q[0]));
        check("m_op_2", bus.op_2, exp_op2(model_q[0]));
        check("m_opcode", {28'b0, bus.opcode}, {28'b0, model_q[0].opc});
        check("m_rd", {27'b0, bus.rd_addr_out}, {27'b0, model_q[0].rd});
      end else if (zero_out) begin
        check("m_zero_op_1", bus.op_1, 32'h0);
        check("m_zero_op_2", bus.op_2, 32'h0);
        check("m_zero_opcode", {28'b0, bus.opcode}, 32'h0);
        check("m_zero_rd", {27'b0, bus.rd_addr_out}, 32'h0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [4:0] rs1a, input logic [31:0] rs1v,
                       input logic [4:0] rs2a, input logic [31:0] rs2v,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input logic [1:0] s1, input logic s2,
                       input logic [3:0] opc, input logic [4:0] rd);
    bus.in_valid      = 1'b1;
    bus.rs1_addr      = rs1a;
    bus.rs1_data      = rs1v;
    bus.rs2_addr      = rs2a;
    bus.rs2_data      = rs2v;
    bus.imm           = imm;
    bus.pc            = pc;
    bus.op1_sel       = s1;
    bus.op2_sel       = s2;
    bus.alu_opcode_in = opc;
    bus.rd_addr_in    = rd;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    bus.wb_en   = en;
    bus.wb_addr = a;
    bus.wb_data = d;
  endtask

  task automatic expect_reset_state(input string tag);
    check({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'h0);
    check({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'h1);
    check({tag, "_op_1"}, bus.op_1, 32'h0);
    check({tag, "_op_2"}, bus.op_2, 32'h0);
    check({tag, "_opcode"}, {28'b0, bus.opcode}, 32'h0);
    check({tag, "_rd"}, {27'b0, bus.rd_addr_out}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive(5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, OP1_SEL_RS1, OP2_SEL_RS2, ALU_ADD, 5'd0);
    bus.in_valid = 1'b0;
    set_wb(1'b0, 5'd0, 32'h0);

    tick(); tick();
    reset = 1'b0;
    expect_reset_state("rst");

    // single issue
    bus.out_ready = 1'b1;
    drive(5'd1, 32'h7FFFFFFF, 5'd2, 32'h5, 32'h1, 32'h0, OP1_SEL_RS1, OP2_SEL_IMM, ALU_ADD, 5'd3);
    tick(); bus.in_valid = 1'b0;
    check("t1_out_valid", {31'b0, bus.out_valid}, 32'h1);
    check("t1_op_1", bus.op_1, 32'h7FFFFFFF);
    check("t1_op_2", bus.op_2, 32'h00000001);
    check("t1_opcode", {28'b0, bus.opcode}, {28'b0, ALU_ADD});
    tick();
    check("t1_out_valid_after", {31'b0, bus.out_valid}, 32'h0);

    // capture forwarding, then x0 never forwarded
    drive(5'd5, 32'h11, 5'd0, 32'h0, 32'h0, 32'h0, OP1_SEL_RS1, OP2_SEL_RS2, ALU_ADD, 5'd4);
    set_wb(1'b1, 5'd5, 32'hDEADBEEF);
    tick(); bus.in_valid = 1'b0; set_wb(1'b0, 5'd0, 32'h0);
    check("t2_fwd_op_1", bus.op_1, 32'hDEADBEEF);
    drive(5'd0, 32'h22, 5'd0, 32'h0, 32'h0, 32'h0, OP1_SEL_RS1, OP2_SEL_RS2, ALU_ADD, 5'd4);
    set_wb(1'b1, 5'd0, 32'hDEADBEEF);
    tick(); bus.in_valid = 1'b0; set_wb(1'b0, 5'd0, 32'h0);
    check("t2_x0_op_1", bus.op_1, 32'h22);
    tick();

    // stall with skid fill, C held upstream until accepted
    bus.out_ready = 1'b0;
    drive(5'd1, 32'hA1, 5'd0, 32'h0, 32'h0, 32'h0, OP1_SEL_RS1, OP2_SEL_RS2, ALU_SUB, 5'd1);
    tick();
    check("t3_ready_a", {31'b0, bus.in_ready}, 32'h1);
    drive(5'd2, 32'hB2, 5'd0, 32'h0, 32'h0, 32'h0, OP1_SEL_RS1, OP2_SEL_RS2, ALU_AND, 5'd2);
    tick();
    check("t3_ready_b", {31'b0, bus.in_ready}, 32'h0);
    check("t3_head_a", bus.op_1, 32'hA1);
    drive(5'd3, 32'hC3, 5'd0, 32'h0, 32'h0, 32'h0, OP1_SEL_RS1, OP2_SEL_RS2, ALU_XOR, 5'd3);
    tick();
    check("t3_still_a", bus.op_1, 32'hA1);
    check("t3_ready_c", {31'b0, bus.in_ready}, 32'h0);
    bus.out_ready = 1'b1;
    tick();
    check("t3_head_b", bus.op_1, 32'hB2);
    check("t3_ready_open", {31'b0, bus.in_ready}, 32'h1);
    tick(); bus.in_valid = 1'b0;
    check("t3_head_c", bus.op_1, 32'hC3);
    check("t3_rd_c", {27'b0, bus.rd_addr_out}, 32'h3);
    tick();
    check("t3_drained", {31'b0, bus.out_valid}, 32'h0);

    // hold forwarding on the main entry, then on the skid entry
    bus.out_ready = 1'b0;
    drive(5'd0, 32'h0, 5'd7, 32'h55, 32'h0, 32'h0, OP1_SEL_RS1, OP2_SEL_RS2, ALU_OR, 5'd7);
    tick(); bus.in_valid = 1'b0;
    check("t4_op_2_before", bus.op_2, 32'h55);
    set_wb(1'b1, 5'd7, 32'h80000000);
    tick(); set_wb(1'b0, 5'd0, 32'h0);
    check("t4_op_2_hold", bus.op_2, 32'h80000000);
    check("t4_out_valid", {31'b0, bus.out_valid}, 32'h1);
    drive(5'd9, 32'h99, 5'd0, 32'h0, 32'h0, 32'h0, OP1_SEL_RS1, OP2_SEL_RS2, ALU_SLT, 5'd9);
    tick(); bus.in_valid = 1'b0;
    set_wb(1'b1, 5'd9, 32'h12345678);
    tick(); set_wb(1'b0, 5'd0, 32'h0);
    bus.out_ready = 1'b1;
    tick();
    check("t4_skid_hold", bus.op_1, 32'h12345678);
    tick();

    // flush with both entries full and a valid input
    bus.out_ready = 1'b0;
    drive(5'd1, 32'hF1, 5'd0, 32'h0, 32'h0, 32'h0, OP1_SEL_RS1, OP2_SEL_RS2, ALU_ADD, 5'd1);
    tick();
    drive(5'd2, 32'hF2, 5'd0, 32'h0, 32'h0, 32'h0, OP1_SEL_RS1, OP2_SEL_RS2, ALU_ADD, 5'd2);
    tick();
    drive(5'd3, 32'hF3, 5'd0, 32'h0, 32'h0, 32'h0, OP1_SEL_RS1, OP2_SEL_RS2, ALU_ADD, 5'd3);
    bus.flush = 1'b1;
    tick(); bus.flush = 1'b0; bus.in_valid = 1'b0;
    check("t5_out_valid", {31'b0, bus.out_valid}, 32'h0);
    check("t5_in_ready", {31'b0, bus.in_ready}, 32'h1);
    tick();
    check("t5_dropped", {31'b0, bus.out_valid}, 32'h0);

    // operand select: PC, ZERO, reserved
    bus.out_ready = 1'b1;
    drive(5'd1, 32'hFFFF, 5'd0, 32'h0, 32'h0, 32'h00000100, OP1_SEL_PC, OP2_SEL_RS2, ALU_ADD, 5'd1);
    tick();
    check("t6_pc", bus.op_1, 32'h00000100);
    drive(5'd1, 32'hFFFF, 5'd0, 32'h0, 32'h0, 32'h00000100, OP1_SEL_ZERO, OP2_SEL_RS2, ALU_ADD, 5'd1);
    tick();
    check("t6_zero", bus.op_1, 32'h0);
    drive(5'd1, 32'hABCD, 5'd0, 32'h0, 32'h0, 32'h00000200, 2'b11, OP2_SEL_RS2, ALU_ADD, 5'd1);
    tick(); bus.in_valid = 1'b0;
    check("t6_reserved", bus.op_1, 32'h0);
    tick();

    // reset while stalled with both entries full
    bus.out_ready = 1'b0;
    drive(5'd4, 32'h44, 5'd5, 32'h55, 32'h66, 32'h77, OP1_SEL_RS1, OP2_SEL_IMM, ALU_SRA, 5'd8);
    tick();
    drive(5'd6, 32'h88, 5'd7, 32'h99, 32'hAA, 32'hBB, OP1_SEL_PC, OP2_SEL_RS2, ALU_SLL, 5'd9);
    tick(); bus.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_reset_state("t6_rst");

    // mixed traffic with writebacks and occasional flush, checked by the model
    for (int n = 0; n < 120; n++) begin
      drive(5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom,
            $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 9)), 5'($urandom_range(0, 31)));
      bus.in_valid  = 1'($urandom_range(0, 3) != 0);
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
      bus.flush = ($urandom_range(0, 15) == 0);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    set_wb(1'b0, 5'd0, 32'h0);
    bus.out_ready = 1'b1;
    tick(); tick(); tick();
    check("final_drained", {31'b0, bus.out_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Execute-stage input register that sits directly upstream of the 32-bit ALU. It accepts decoded instructions through a valid/ready handshake and forwards writeback results into source operands, including while entries are held. It selects and registers OP_1/OP_2/OPCODE for the ALU. A 2-entry skid buffer gives a fully registered IN_READY and loses no instruction under downstream stall.

Parameters:
XLEN, 32, operand/data width
REG_ADDR_W, 5, register address width

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET  in  1  reset, synchronous, active-high
FLUSH  in  1  synchronous discard of all buffered entries
IN_VALID  in  1  upstream instruction valid
IN_READY  out  1  stage can accept (registered)
RS1_ADDR  in  5  source 1 register index
RS2_ADDR  in  5  source 2 register index
RS1_DATA  in  32  register file read data 1
RS2_DATA  in  32  register file read data 2
IMM  in  32  sign-extended immediate
PC  in  32  instruction address
OP1_SEL  in  2  OP_1 source: RS1 / PC / ZERO (globals encodings)
OP2_SEL  in  1  OP_2 source: RS2 / IMM
ALU_OPCODE_IN  in  4  ALU operation code (globals ALU_* encodings)
RD_ADDR_IN  in  5  destination register
WB_EN  in  1  writeback write enable
WB_ADDR  in  5  writeback destination
WB_DATA  in  32  writeback value
OUT_VALID  out  1  OP_1/OP_2/OPCODE valid toward ALU
OUT_READY  in  1  downstream accepts
OP_1  out  32  ALU operand 1
OP_2  out  32  ALU operand 2
OPCODE  out  4  ALU opcode
RD_ADDR_OUT  out  5  destination of presented instruction

Behaviour:
- Reset (RESET=1 at edge): main and skid entries invalid. OUT_VALID=0. IN_READY=1 from the first cycle after reset. OP_1, OP_2, OPCODE and RD_ADDR_OUT are 0.
- Accept when IN_VALID&IN_READY. Transfer out when OUT_VALID&OUT_READY.
- Entries store the raw forwarded RS1/RS2 values and addresses, IMM, PC, selects, opcode and RD. OP_1 and OP_2 are mux outputs from the main entry only, with no combinational path from inputs.
- Capture forwarding: if WB_EN, WB_ADDR!=0 and WB_ADDR==RSx_ADDR, the stored RSx value is WB_DATA, otherwise RSx_DATA.
- Hold forwarding: each cycle, every valid entry with WB_EN, WB_ADDR!=0 and WB_ADDR==stored RSx_ADDR replaces its stored RSx value with WB_DATA. This is visible on OP_1/OP_2 the next cycle.
- Index x0 is never forwarded. The value for x0 stays as captured from RS1_DATA/RS2_DATA.
- OP1_SEL=ZERO gives OP_1=0. OP1_SEL=PC gives the stored PC. The reserved encoding gives 0.
- Skid rules:
  - Main empty, or main transferring, with skid empty: the input loads main.
  - Main full and not transferring: the input loads skid, and IN_READY goes 0 the next cycle.
  - Main transferring with skid full: skid moves to main, and IN_READY goes 1 the next cycle.
- IN_READY is the registered complement of skid-valid. Ordering is strictly FIFO.
- Latency: accept to OUT_VALID is 1 cycle. Throughput is 1 per cycle while OUT_READY=1.
- FLUSH invalidates both entries and forces IN_READY=1 next cycle. It overrides a same-cycle accept, and the input is dropped. A same-cycle transfer is still considered completed by downstream.
- RESET overrides FLUSH and every other input.
- Forwarding updates on a same-cycle capture plus a hold use the same WB values, and there is no conflict. A same-cycle transfer plus a hold update of the transferring entry is allowed, because downstream has already sampled the old value.

Decomposition:
- globals.vh:
  - existing ALU_* 4-bit opcodes;
  - new OP1_SEL_RS1 = 2'b00, OP1_SEL_PC = 2'b01, OP1_SEL_ZERO = 2'b10;
  - OP2_SEL_RS2 = 1'b0, OP2_SEL_IMM = 1'b1.
- Sub-module operand_entry: one buffered entry holding its valid bit, capture-forwarding and hold-forwarding update. It is instantiated twice (main, skid).
- The operand mux is local combinational logic in alu_operand_stage.

Test Plan:
1. Reset then single issue:
   - Stimulus: RS1_DATA=0x7FFFFFFF, OP2_SEL=IMM with IMM=1, opcode ALU_ADD, OUT_READY=1.
   - Required: next cycle OUT_VALID=1, OP_1=0x7FFFFFFF, OP_2=0x00000001, OPCODE=ALU_ADD. OUT_VALID=0 the cycle after.
2. Capture forwarding:
   - Stimulus: RS1_ADDR=5, RS1_DATA=0x11, with WB_EN=1, WB_ADDR=5, WB_DATA=0xDEADBEEF the same cycle.
   - Required: OP_1=0xDEADBEEF. Repeat with WB_ADDR=0 and RS1_ADDR=0: OP_1=RS1_DATA.
3. Stall with skid fill:
   - Stimulus: OUT_READY=0, three back-to-back IN_VALID instructions A, B, C.
   - Required: A in main and B in skid. IN_READY=0 before C, and C is not accepted. After OUT_READY=1: A, B, C emerge in order, one per cycle.
4. Hold forwarding:
   - Stimulus: entry stalled with RS2_ADDR=7 and OP2_SEL=RS2. Pulse WB_EN, WB_ADDR=7, WB_DATA=0x80000000.
   - Required: OP_2 changes to 0x80000000 the next cycle while OUT_VALID stays 1.
5. Flush: FLUSH with both entries full and IN_VALID=1 -> next cycle OUT_VALID=0 and IN_READY=1. The input is not captured.
6. Operand select and reset mid-stall:
   - Stimulus: OP1_SEL=PC with PC=0x00000100, then OP1_SEL=ZERO. Then assert RESET during a stall.
   - Required: OP_1=0x00000100, then 0x00000000. After reset, all outputs are 0 and IN_READY=1.
